// File: rtl/aes_xfer_sched.sv
// aes_xfer_sched
//   Sequences AES block jobs over an AHB master. For each block it fetches
//   WORDS_PER_BLK words from src, pulses the AES core start, waits for
//   core_done, then writes the block to dst. It repeats this for num_blocks
//   blocks.
//
//   Optional feature: define AES_SCHED_TIMEOUT_EN to add a core-wait
//   watchdog. If core_done has not arrived after TIMEOUT_CYC cycles in
//   CORE_WAIT, the job aborts through ERR. When the macro is not defined,
//   CORE_WAIT waits indefinitely and no counter is built.
//
// Ports
//   hclk, n_rst              clock; asynchronous active-low reset
//   start, src_addr,
//   dst_addr, num_blocks     job request; params latched on accepted start
//   ahb_mode, ahb_enable,
//   raddr, waddr             master control (mode 0 fetch / 1 write)
//   word_done, ahb_err       master beat completion / bus error
//   core_start, core_done    AES core handshake
//   busy, done, error,
//   blk_count                host status
module aes_xfer_sched #(
    parameter int WORDS_PER_BLK = 4,
    parameter int CNT_W         = 16,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic             hclk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] num_blocks,
    output logic             ahb_mode,
    output logic             ahb_enable,
    output logic [31:0]      raddr,
    output logic [31:0]      waddr,
    input  logic             word_done,
    input  logic             ahb_err,
    output logic             core_start,
    input  logic             core_done,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] blk_count
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] CORE_GO   = 3'd2;
    localparam logic [2:0] CORE_WAIT = 3'd3;
    localparam logic [2:0] STORE     = 3'd4;
    localparam logic [2:0] NEXT      = 3'd5;
    localparam logic [2:0] ERR       = 3'd6;

    localparam int WC_W = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_BLK - 1);

    logic [2:0]       state;
    logic [31:0]      cur_src;
    logic [31:0]      cur_dst;
    logic [CNT_W-1:0] num_lat;
    logic [WC_W-1:0]  word_cnt;
    logic [CNT_W-1:0] blk_nxt;

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    assign blk_nxt    = blk_count + CNT_W'(1);
    assign ahb_enable = (state == FETCH) || (state == STORE);
    assign core_start = (state == CORE_GO);
    assign busy       = (state != IDLE);
    assign raddr      = cur_src;
    assign waddr      = cur_dst;

    always_ff @(posedge hclk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            cur_src   <= '0;
            cur_dst   <= '0;
            num_lat   <= '0;
            word_cnt  <= '0;
            blk_count <= '0;
            ahb_mode  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        if (num_blocks != '0) begin
                            cur_src   <= src_addr;
                            cur_dst   <= dst_addr;
                            num_lat   <= num_blocks;
                            blk_count <= '0;
                            word_cnt  <= '0;
                            ahb_mode  <= 1'b0;
                            state     <= FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    // A bus error wins over a beat completion in the same cycle.
                    if (ahb_err) begin
                        error <= 1'b1;
                        state <= ERR;
                    end else if (word_done) begin
                        cur_src <= cur_src + 32'd4;
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= CORE_GO;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                CORE_GO: begin
`ifdef AES_SCHED_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= CORE_WAIT;
                end
                CORE_WAIT: begin
                    // ahb_mode flips only on entering STORE so the master
                    // never sees a glitch while the bus is idle.
                    if (core_done) begin
                        ahb_mode <= 1'b1;
                        state    <= STORE;
                    end
`ifdef AES_SCHED_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        error <= 1'b1;
                        state <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                STORE: begin
                    if (ahb_err) begin
                        error <= 1'b1;
                        state <= ERR;
                    end else if (word_done) begin
                        cur_dst <= cur_dst + 32'd4;
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= NEXT;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                NEXT: begin
                    blk_count <= blk_nxt;
                    if (blk_nxt == num_lat) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        ahb_mode <= 1'b0;
                        state    <= FETCH;
                    end
                end
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_xfer_sched.sv
// Bench for aes_xfer_sched. It plays the AHB master (random beat latency,
// optional error injection) and the AES core (configurable latency). It
// checks the address streams and job status against expectations computed
// from the job parameters.
module tb_aes_xfer_sched;

    localparam int WPB = 4;
`ifdef AES_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO = 1024;

    logic        hclk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] num_blocks;
    logic        ahb_mode, ahb_enable;
    logic [31:0] raddr, waddr;
    logic        word_done, ahb_err;
    logic        core_start, core_done;
    logic        busy, done, error;
    logic [15:0] blk_count;

    aes_xfer_sched dut (
        .hclk(hclk), .n_rst(n_rst), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .num_blocks(num_blocks), .ahb_mode(ahb_mode),
        .ahb_enable(ahb_enable), .raddr(raddr), .waddr(waddr),
        .word_done(word_done), .ahb_err(ahb_err), .core_start(core_start),
        .core_done(core_done), .busy(busy), .done(done), .error(error),
        .blk_count(blk_count)
    );

    always #5 hclk = ~hclk;

    int total = 0;
    int bad   = 0;
    int prev_blk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Run one job; eb = index of read beat that gets ahb_err (-1 none),
    // cdly = extra core latency (core_done after cdly+1 CORE_WAIT cycles).
    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int mw, input int eb, input int cdly, input bit mid_start);
        logic [31:0] rq[$];
        logic [31:0] wq[$];
        int dn = 0, cs = 0, cw = 0, cyc = 0, post = 0, rbeats = 0;
        int err_cyc = -1, drop_cyc = -1, cd_cnt = 0, wdly;
        bit waiting = 0, tmo;
        int er, ew, eblk, edn, eerr, ecs, ecw;

        word_done = 0; core_done = 0; ahb_err = 0;
        src_addr = s; dst_addr = d; num_blocks = 16'(n); start = 1;
        wdly = $urandom_range(mw, 0);
        @(negedge hclk);
        while (post < 3 && cyc < 6000) begin
            start = 0; word_done = 0; core_done = 0; ahb_err = 0;
            if (cyc == 0) begin
                chk("lat_en", ahb_enable, n != 0);
                chk("lat_busy", busy, n != 0);
                src_addr = $urandom; dst_addr = $urandom; num_blocks = 16'($urandom);
            end
            if (err_cyc >= 0 && cyc == err_cyc + 1) begin
                chk("err_en_off", ahb_enable, 0);
                chk("err_flag", error, 1);
            end
            if (err_cyc >= 0 && drop_cyc < 0 && !busy) drop_cyc = cyc;
            if (done) dn++;
            if (waiting && !error) cw++;
            if (core_start) begin
                cs++; cd_cnt = cdly + 1; waiting = 1;
            end else if (cd_cnt > 0) begin
                cd_cnt--;
                if (cd_cnt == 0) begin core_done = 1; waiting = 0; end
            end
            if (ahb_enable) begin
                if (wdly == 0) begin
                    if (!ahb_mode && rbeats == eb) begin
                        ahb_err = 1; word_done = 1; err_cyc = cyc;
                    end else begin
                        word_done = 1;
                        if (ahb_mode) wq.push_back(waddr);
                        else begin rq.push_back(raddr); rbeats++; end
                    end
                    wdly = $urandom_range(mw, 0);
                end else wdly--;
                if ($urandom_range(7, 0) == 0) core_done = 1;  // must be ignored
            end else if (busy && $urandom_range(3, 0) == 0) begin
                word_done = 1;                                  // must be ignored
            end
            if (mid_start && busy && cyc == 5) start = 1;       // must be ignored
            if (!busy) post++;
            cyc++;
            @(negedge hclk);
        end
        start = 0; word_done = 0; core_done = 0; ahb_err = 0;
        chk("job_bound", cyc < 6000, 1);

        // Expected outcome from the job rules.
        tmo = TMO_EN && n != 0 && eb < 0 && (cdly + 1 > TMO);
        if (n == 0) begin
            er = 0; ew = 0; eblk = prev_blk; edn = 1; eerr = 0; ecs = 0;
        end else if (eb >= 0) begin
            er = eb; ew = WPB * (eb / WPB); eblk = eb / WPB; edn = 0; eerr = 1; ecs = eb / WPB;
        end else if (tmo) begin
            er = WPB; ew = 0; eblk = 0; edn = 0; eerr = 1; ecs = 1;
        end else begin
            er = WPB * n; ew = WPB * n; eblk = n; edn = 1; eerr = 0; ecs = n;
        end
        ecw = tmo ? TMO : ecs * (cdly + 1);
        prev_blk = eblk;

        chk("n_reads", rq.size(), er);
        chk("n_writes", wq.size(), ew);
        for (int i = 0; i < rq.size() && i < er; i++) chk("raddr", rq[i], s + 32'(4 * i));
        for (int i = 0; i < wq.size() && i < ew; i++) chk("waddr", wq[i], d + 32'(4 * i));
        chk("done_cnt", dn, edn);
        chk("core_starts", cs, ecs);
        chk("wait_cycles", cw, ecw);
        chk("error", error, eerr);
        chk("blk_count", blk_count, eblk);
        chk("busy_end", busy, 0);
        if (eb >= 0) chk("err_drop", drop_cyc - err_cyc, 2);
    endtask

    initial begin
        n_rst = 0; start = 0; src_addr = 0; dst_addr = 0; num_blocks = 0;
        word_done = 0; ahb_err = 0; core_done = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_en", ahb_enable, 0);
        chk("rst_mode", ahb_mode, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_cs", core_start, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_blk", blk_count, 0);
        repeat (2) @(negedge hclk);
        n_rst = 1;
        @(negedge hclk);

        run_job(32'h1000, 32'h2000, 1, 0, -1, 0, 0);
        run_job(32'h4000, 32'h8000, 3, 3, -1, $urandom_range(5, 0), 1);
        run_job(32'h0100, 32'h0200, 3, 2, 6, 2, 0);
        run_job($urandom, $urandom, 2, 3, -1, 1, 0);
        run_job(32'hFFFF_FFF8, 32'hFFFF_FFF0, 1, 1, -1, 0, 0);
        run_job(32'h0010, 32'h0020, 1, 0, -1, 1100, 0);
        run_job(32'h5555, 32'h6666, 0, 0, -1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            int n, eb;
            n  = $urandom_range(4, 1);
            eb = ($urandom_range(1, 0) == 1) ? int'($urandom_range(WPB * n - 1, 0)) : -1;
            run_job($urandom, $urandom, n, 3, eb, $urandom_range(4, 0), 1);
        end

        // Asynchronous reset in the middle of a job.
        src_addr = 32'h3000; dst_addr = 32'h7000; num_blocks = 16'd2; start = 1;
        @(negedge hclk);
        start = 0; word_done = 1;
        repeat (6) @(negedge hclk);
        #2 n_rst = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_en", ahb_enable, 0);
        chk("mid_rst_raddr", raddr, 0);
        chk("mid_rst_blk", blk_count, 0);
        chk("mid_rst_done", done, 0);
        word_done = 0;
        @(negedge hclk);
        n_rst = 1;
        prev_blk = 0;
        @(negedge hclk);
        run_job(32'h0000_0003, 32'h0000_0101, 2, 1, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
